// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder slice (two half adders)
// walks the operands LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, ps;
    logic             c;
    logic [CW-1:0]    cnt;

    logic p, g1, s, g2, c_nxt, last;

    // Shared bit slice: HA1 on the operand bits, HA2 folds in the held carry.
    assign p     = ra[0] ^ rb[0];
    assign g1    = ra[0] & rb[0];
    assign s     = p ^ c;
    assign g2    = p & c;
    assign c_nxt = g1 | g2;
    assign last  = (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done is decoded from the one-cycle DONE state, so it is glitch-free.
    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra   <= '0;
            rb   <= '0;
            ps   <= '0;
            c    <= 1'b0;
            cnt  <= '0;
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        c   <= cin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    ps  <= {s, ps[WIDTH-1:1]};
                    ra  <= {1'b0, ra[WIDTH-1:1]};
                    rb  <= {1'b0, rb[WIDTH-1:1]};
                    c   <= c_nxt;
                    cnt <= cnt + 1'b1;
                    // Result ports only move here, so partial sums never leak out.
                    if (last) begin
                        sum  <= {s, ps[WIDTH-1:1]};
                        cout <= c_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboarded bench for serial_add_ctrl at WIDTH=8 and WIDTH=16.
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ndone8 = 0;
    logic [8:0]  q8[$];
    logic [16:0] q16[$];
    int          dtimes8[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on every done pulse.
    logic       prev_rst = 1'b1, prev_done8 = 1'b0, prev_done16 = 1'b0;
    logic [7:0] prev_sum8 = '0;
    logic [15:0] prev_sum16 = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (done8) begin
                ndone8++;
                dtimes8.push_back(cyc);
                chk("done8_pulse", 32'(prev_done8), 32'd0);
                if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
                else chk("sum8", 32'({cout8, sum8}), 32'(q8.pop_front()));
            end else if (!prev_rst) begin
                chk("sum8_hold", 32'({cout8, sum8}), 32'({cout8, prev_sum8}));
            end
            if (done16) begin
                chk("done16_pulse", 32'(prev_done16), 32'd0);
                if (q16.size() == 0) chk("done16_unexpected", 32'd1, 32'd0);
                else chk("sum16", 32'({cout16, sum16}), 32'(q16.pop_front()));
            end else if (!prev_rst) begin
                chk("sum16_hold", 32'(sum16), 32'(prev_sum16));
            end
        end
        prev_rst    = rst;
        prev_done8  = done8;
        prev_done16 = done16;
        prev_sum8   = sum8;
        prev_sum16  = sum16;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in IDLE; returns in IDLE after the operation completes.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic ci, input bit chk_lat);
        int  nb = 0;
        bit  got = 0;
        start8 = 1'b1; a8 = x; b8 = y; cin8 = ci;
        q8.push_back(9'(x) + 9'(y) + 9'(ci));
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        for (int i = 0; i < 40 && !got; i++) begin
            if (busy8) nb++;
            if (done8) got = 1;
            else tick();
        end
        if (!got) chk("timeout8", 32'd0, 32'd1);
        if (chk_lat) chk("busy8_cycles", 32'(nb), 32'd8);
        tick();
    endtask

    task automatic run16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        bit got = 0;
        start16 = 1'b1; a16 = x; b16 = y; cin16 = ci;
        q16.push_back(17'(x) + 17'(y) + 17'(ci));
        tick();
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        for (int i = 0; i < 60 && !got; i++) begin
            if (done16) got = 1;
            else tick();
        end
        if (!got) chk("timeout16", 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n0;
        bit  got;
        rst = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; cin8 = 0;
        start16 = 0; a16 = '0; b16 = '0; cin16 = 0;
        repeat (3) tick();
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_sum8", 32'({cout8, sum8}), 32'd0);
        chk("rst_sum16", 32'({busy16, done16, cout16, sum16}), 32'd0);
        rst = 1'b0;
        tick();

        // directed adds and carry chains
        run8(8'h5A, 8'h3C, 1'b0, 1);
        run8(8'hFF, 8'h01, 1'b0, 1);
        run8(8'hFF, 8'hFF, 1'b1, 1);

        // start while busy must be ignored
        n0 = ndone8;
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
        q8.push_back(9'h030);
        tick();
        start8 = 1'b0;
        tick(); tick();
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
        tick();
        start8 = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done8) got = 1;
            else tick();
        end
        if (!got) chk("timeout8_busy_start", 32'd0, 32'd1);
        repeat (12) tick();
        chk("busy_start_done_count", 32'(ndone8 - n0), 32'd1);
        chk("busy_start_queue", 32'(q8.size()), 32'd0);

        // reset mid-operation aborts with no done
        n0 = ndone8;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_sum", 32'({cout8, sum8}), 32'd0);
        rst = 1'b0;
        repeat (12) tick();
        chk("abort_no_done", 32'(ndone8 - n0), 32'd0);
        run8(8'h0F, 8'h01, 1'b1, 1);

        // back-to-back with start held high
        dtimes8.delete();
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
        q8.push_back(9'h003);
        tick();
        chk("b2b_accept1", 32'(busy8), 32'd1);
        a8 = 8'h80; b8 = 8'h80;
        q8.push_back(9'h100);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (busy8 && !done8 && dtimes8.size() == 1) got = 1;
        end
        start8 = 1'b0;
        if (!got) chk("timeout8_b2b", 32'd0, 32'd1);
        for (int i = 0; i < 40 && dtimes8.size() < 2; i++) tick();
        if (dtimes8.size() < 2) chk("b2b_two_dones", 32'(dtimes8.size()), 32'd2);
        else chk("b2b_spacing", 32'(dtimes8[1] - dtimes8[0]), 32'd10);
        repeat (2) tick();

        // random sweep at both widths
        for (int i = 0; i < 1000; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 0);
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        run16(16'hFFFF, 16'h0000, 1'b1);
        run16(16'hFFFF, 16'hFFFF, 1'b1);

        repeat (3) tick();
        chk("q8_drained", 32'(q8.size()), 32'd0);
        chk("q16_drained", 32'(q16.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
